// File: rtl/seg7_scan_2digit_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_2digit_pkg
//   Shared display definitions for the counter display path.
//   - SEG_0..SEG_9, SEG_DASH, SEG_BLANK: active-high segment codes in
//     {a,b,c,d,e,f,g} order (bit 6 = a, bit 0 = g).
//   - AN_NONE / AN_ONES / AN_TENS: active-high anode slot encodings
//     (bit 0 = ones digit, bit 1 = tens digit).
//   - scan_state_e: which digit slot the scanner is currently driving.
//   - seg_polarity / an_polarity: map active-high codes onto the board's
//     pin polarity.
// ---------------------------------------------------------------------------
package seg7_scan_2digit_pkg;

    // Active-high segment codes, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high anode slot encodings
    localparam logic [1:0] AN_NONE = 2'b00;
    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

    // Scan slot currently being driven
    typedef enum logic {
        SHOW0 = 1'b0,   // ones digit
        SHOW1 = 1'b1    // tens digit
    } scan_state_e;

    // Convert an active-high segment pattern to pin polarity
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg_hi,
                                                input logic       active_low);
        logic [6:0] seg_pin;
        if (active_low) begin
            seg_pin = ~seg_hi;
        end else begin
            seg_pin = seg_hi;
        end
        return seg_pin;
    endfunction

    // Convert an active-high anode pattern to pin polarity
    function automatic logic [1:0] an_polarity(input logic [1:0] an_hi,
                                               input logic       active_low);
        logic [1:0] an_pin;
        if (active_low) begin
            an_pin = ~an_hi;
        end else begin
            an_pin = an_hi;
        end
        return an_pin;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//   Combinational BCD to 7-segment decoder, active-high output.
//   Codes 10..15 are not valid BCD and show a single dash (segment g).
//   Ports:
//     bcd  input  [3:0]  digit code
//     seg  output [6:0]  {a,b,c,d,e,f,g}, seg[6] = a, seg[0] = g
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_scan_2digit_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup; anything outside 0..9 falls through to the dash
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_2digit.sv
// ---------------------------------------------------------------------------
// seg7_scan_2digit
//   Two-digit multiplexed 7-segment display driver. The ones and tens
//   digits are latched once per refresh frame (at the tens->ones slot
//   boundary) so a frame never mixes old and new values. Each slot opens
//   with a short anode-off guard to suppress ghosting, and a zero tens
//   digit can be blanked. Seg and An are registered, one cycle behind the
//   scan position.
//   Parameters:
//     SCAN_DIV   clock cycles per digit slot (>= 2)
//     BLANK_CYC  anode-off cycles at the start of each slot (< SCAN_DIV)
//     ACTIVE_LOW 1: Seg/An pins active-low, 0: active-high
//     BLANK_LZ   1: blank the tens digit when its latched value is 0
//   Ports:
//     Clk  input       system clock, rising edge
//     R    input       asynchronous active-high reset
//     D0   input  [3:0] ones digit (BCD)
//     D1   input  [3:0] tens digit (BCD)
//     En   input       display enable; 0 blanks outputs and freezes scan
//     Seg  output [6:0] segments {a..g}, Seg[6] = a
//     An   output [1:0] anode enables, An[0] = ones, An[1] = tens
// ---------------------------------------------------------------------------
module seg7_scan_2digit
    import seg7_scan_2digit_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic       Clk,
    input  logic       R,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic       En,
    output logic [6:0] Seg,
    output logic [1:0] An
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic             AL_B      = (ACTIVE_LOW != 0);
    localparam logic             LZ_B      = (BLANK_LZ != 0);
    localparam logic [6:0]       SEG_OFF   = seg_polarity(SEG_BLANK, AL_B);
    localparam logic [1:0]       AN_OFF    = an_polarity(AN_NONE, AL_B);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       d0_q_r;
    logic [3:0]       d1_q_r;
    logic             latch_s;
    logic [3:0]       digit_s;
    logic [6:0]       seg_dec_s;
    logic [6:0]       seg_hi_s;
    logic [1:0]       an_hi_s;
    logic             guard_s;
    logic             tens_zero_s;
    logic [6:0]       seg_nxt_s;
    logic [1:0]       an_nxt_s;

    // Scan state, slot counter and frame latches
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_r <= SHOW0;
            cnt_r   <= CNT_ZERO;
            d0_q_r  <= 4'd0;
            d1_q_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                d0_q_r <= D0;
                d1_q_r <= D1;
            end else begin
                d0_q_r <= d0_q_r;
                d1_q_r <= d1_q_r;
            end
        end
    end

    // Next scan position; everything holds while the display is disabled.
    // The frame latch fires only when the tens slot ends, so both digits
    // of a frame always come from the same sample.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        if (En) begin
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s = CNT_ZERO;
                case (state_r)
                    SHOW0: begin
                        state_nxt_s = SHOW1;
                        latch_s     = 1'b0;
                    end
                    SHOW1: begin
                        state_nxt_s = SHOW0;
                        latch_s     = 1'b1;
                    end
                    default: begin
                        state_nxt_s = SHOW0;
                        latch_s     = 1'b0;
                    end
                endcase
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Digit shown in the current slot
    always_comb begin
        digit_s = d0_q_r;
        case (state_r)
            SHOW0:   digit_s = d0_q_r;
            SHOW1:   digit_s = d1_q_r;
            default: digit_s = d0_q_r;
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (digit_s),
        .seg (seg_dec_s)
    );

    // Active-high anode/segment pattern for the current (state, cnt).
    // Segments keep showing the slot's digit during the guard and when the
    // tens anode is suppressed; only the anodes are gated.
    always_comb begin
        guard_s     = (cnt_r < BLANK_LIM);
        tens_zero_s = LZ_B && (d1_q_r == 4'd0);
        seg_hi_s    = SEG_BLANK;
        an_hi_s     = AN_NONE;
        if (En) begin
            seg_hi_s = seg_dec_s;
            if (guard_s) begin
                an_hi_s = AN_NONE;
            end else begin
                case (state_r)
                    SHOW0:   an_hi_s = AN_ONES;
                    SHOW1:   an_hi_s = tens_zero_s ? AN_NONE : AN_TENS;
                    default: an_hi_s = AN_NONE;
                endcase
            end
        end else begin
            seg_hi_s = SEG_BLANK;
            an_hi_s  = AN_NONE;
        end
        seg_nxt_s = seg_polarity(seg_hi_s, AL_B);
        an_nxt_s  = an_polarity(an_hi_s, AL_B);
    end

    // Output registers keep the pins glitch-free
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            Seg <= SEG_OFF;
            An  <= AN_OFF;
        end else begin
            Seg <= seg_nxt_s;
            An  <= an_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_2digit
//   Two instances share the inputs: dut_a (active-low, leading-zero blank)
//   and dut_b (active-high, no blanking). A frame-position model predicts
//   both outputs every cycle; literal checks pin key display values.
// ---------------------------------------------------------------------------
module tb_seg7_scan_2digit;

    localparam int SD = 4;
    localparam int BC = 1;

    logic       Clk = 1'b0;
    logic       R   = 1'b1;
    logic [3:0] D0  = 4'd7;
    logic [3:0] D1  = 4'd4;
    logic       En  = 1'b1;
    logic [6:0] seg_a;
    logic [1:0] an_a;
    logic [6:0] seg_b;
    logic [1:0] an_b;

    int checks   = 0;
    int failures = 0;

    seg7_scan_2digit #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_a (
        .Clk (Clk), .R (R), .D0 (D0), .D1 (D1), .En (En), .Seg (seg_a), .An (an_a)
    );

    seg7_scan_2digit #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut_b (
        .Clk (Clk), .R (R), .D0 (D0), .D1 (D1), .En (En), .Seg (seg_b), .An (an_b)
    );

    always #20 Clk = ~Clk;

    // Model: k = position within the 2*SD-cycle frame, l0/l1 = latched digits.
    // m_* describe what the outputs must show after the latest edge.
    int         k     = 0;
    logic [3:0] l0    = 4'd0;
    logic [3:0] l1    = 4'd0;
    logic       m_on  = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_d0  = 4'd0;
    logic [3:0] m_d1  = 4'd0;

    always @(posedge Clk or posedge R) begin
        if (R) begin
            k <= 0; l0 <= 4'd0; l1 <= 4'd0;
            m_on <= 1'b0; m_pos <= 0; m_d0 <= 4'd0; m_d1 <= 4'd0;
        end else if (En) begin
            m_on <= 1'b1; m_pos <= k; m_d0 <= l0; m_d1 <= l1;
            if (k == 2 * SD - 1) begin
                k <= 0; l0 <= D0; l1 <= D1;
            end else begin
                k <= k + 1;
            end
        end else begin
            m_on <= 1'b0;
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab[0] = 7'h7E; tab[1] = 7'h30; tab[2] = 7'h6D; tab[3] = 7'h79; tab[4] = 7'h33;
        tab[5] = 7'h5B; tab[6] = 7'h5F; tab[7] = 7'h70; tab[8] = 7'h7F; tab[9] = 7'h7B;
        if (d <= 4'd9) return tab[d];
        return 7'h01;
    endfunction

    function automatic logic [6:0] exp_seg(input logic al);
        logic [6:0] v;
        if (!m_on) v = 7'h00;
        else v = decode((m_pos < SD) ? m_d0 : m_d1);
        return al ? ~v : v;
    endfunction

    function automatic logic [1:0] exp_an(input logic al, input logic lz);
        logic [1:0] v;
        int slot;
        int c;
        slot = m_pos / SD;
        c    = m_pos % SD;
        if (!m_on || c < BC) v = 2'b00;
        else if (slot == 1 && lz && m_d1 == 4'd0) v = 2'b00;
        else v = (slot == 0) ? 2'b01 : 2'b10;
        return al ? ~v : v;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model
    always @(negedge Clk) begin
        chk("seg_a", seg_a, exp_seg(1'b1));
        chk("an_a", {5'd0, an_a}, {5'd0, exp_an(1'b1, 1'b1)});
        chk("seg_b", seg_b, exp_seg(1'b0));
        chk("an_b", {5'd0, an_b}, {5'd0, exp_an(1'b0, 1'b0)});
    end

    task automatic lit(input string name, input logic [6:0] sa, input logic [1:0] aa,
                       input logic [6:0] sb, input logic [1:0] ab);
        chk({name, "_seg_a"}, seg_a, sa);
        chk({name, "_an_a"}, {5'd0, an_a}, {5'd0, aa});
        chk({name, "_seg_b"}, seg_b, sb);
        chk({name, "_an_b"}, {5'd0, an_b}, {5'd0, ab});
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        lit("reset_hold", 7'h7F, 2'b11, 7'h00, 2'b00);
        R = 1'b0;
        @(negedge Clk);
        lit("f1_guard", 7'h01, 2'b11, 7'h7E, 2'b00);
        @(negedge Clk);
        lit("f1_ones0", 7'h01, 2'b10, 7'h7E, 2'b01);
        repeat (8) @(negedge Clk);
        lit("f2_ones7", 7'h0F, 2'b10, 7'h70, 2'b01);
        D0 = 4'd3;
        repeat (4) @(negedge Clk);
        lit("f2_tens4", 7'h4C, 2'b01, 7'h33, 2'b10);
        repeat (4) @(negedge Clk);
        lit("f3_ones3", 7'h06, 2'b10, 7'h79, 2'b01);
        D0 = 4'hC;
        repeat (8) @(negedge Clk);
        lit("dash", 7'h7E, 2'b10, 7'h01, 2'b01);
        D0 = 4'd8;
        D1 = 4'd0;
        repeat (8) @(negedge Clk);
        lit("ones8", 7'h00, 2'b10, 7'h7F, 2'b01);
        repeat (4) @(negedge Clk);
        lit("tens0", 7'h01, 2'b11, 7'h7E, 2'b10);

        // Disable mid-slot for 6 cycles
        En = 1'b0;
        @(negedge Clk);
        lit("en_off", 7'h7F, 2'b11, 7'h00, 2'b00);
        repeat (5) @(negedge Clk);
        En = 1'b1;
        repeat (6) @(negedge Clk);

        // Async reset in the middle of the tens slot, away from any edge
        for (int i = 0; i < 16 && k != 5; i++) @(negedge Clk);
        #7;
        R = 1'b1;
        #1;
        lit("async_rst", 7'h7F, 2'b11, 7'h00, 2'b00);
        repeat (2) @(negedge Clk);
        R = 1'b0;
        @(negedge Clk);
        lit("post_rst", 7'h01, 2'b11, 7'h7E, 2'b00);

        // Randomized digits, enable and occasional async resets
        for (int n = 0; n < 600; n++) begin
            @(negedge Clk);
            if (R) begin
                R = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                #7;
                R = 1'b1;
                #1;
                lit("rand_rst", 7'h7F, 2'b11, 7'h00, 2'b00);
            end
            #3;
            if ($urandom_range(0, 2) == 0) D0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) D1 = 4'($urandom_range(0, 15));
            En = ($urandom_range(0, 7) != 0);
        end
        R  = 1'b0;
        En = 1'b1;
        repeat (4) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
